// File: rtl/fpu_seq_pkg.sv
// Definitions shared by the operand sequencer, its result FIFO and the floating-point core.
package fpu_seq_pkg;

  localparam logic [1:0] LOAD_A = 2'd0;
  localparam logic [1:0] LOAD_B = 2'd1;
  localparam logic [1:0] ISSUE  = 2'd2;
  localparam logic [1:0] WAIT_Z = 2'd3;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } fpu_op_e;

endpackage

// File: rtl/fpu_operand_sequencer_if.sv
// Operand input bus, core strobe/ack bus and result output bus of the operand sequencer.
interface fpu_operand_sequencer_if #(
  parameter int WIDTH   = 32,
  parameter int OPSEL_W = 2
);

  // A word or result moves on a rising clk edge where its valid/stb and ready/ack are both high;
  // the sender holds valid and data stable until that edge, and ready never waits on valid.
  logic [WIDTH-1:0]   in_data;
  logic [OPSEL_W-1:0] in_op_sel;
  logic               in_valid;
  logic               in_ready;

  logic [WIDTH-1:0]   fpu_a;
  logic [WIDTH-1:0]   fpu_b;
  logic [OPSEL_W-1:0] fpu_op_sel;
  logic               fpu_a_stb;
  logic               fpu_b_stb;
  logic               fpu_a_ack;
  logic               fpu_b_ack;
  logic [WIDTH-1:0]   fpu_z;
  logic               fpu_z_stb;
  logic               fpu_z_ack;

  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;

  modport slave (
    input  in_data, in_op_sel, in_valid, fpu_a_ack, fpu_b_ack, fpu_z, fpu_z_stb, out_ready,
    output in_ready, fpu_a, fpu_b, fpu_op_sel, fpu_a_stb, fpu_b_stb, fpu_z_ack, out_data, out_valid
  );

  modport master (
    output in_data, in_op_sel, in_valid, fpu_a_ack, fpu_b_ack, fpu_z, fpu_z_stb, out_ready,
    input  in_ready, fpu_a, fpu_b, fpu_op_sel, fpu_a_stb, fpu_b_stb, fpu_z_ack, out_data, out_valid
  );

endinterface

// File: rtl/seq_result_fifo.sv
// Pointer-based result FIFO with occupancy count; full/empty come from the registered count.
module seq_result_fifo
  import fpu_seq_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int RES_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(RES_DEPTH):0] count_o
);

  localparam int AW = $clog2(RES_DEPTH);

  logic [WIDTH-1:0] mem_q [RES_DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(RES_DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

  // Depth is a power of two, so the pointers wrap on their natural overflow.
  always_comb begin
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    rd_d    = do_pop  ? rd_q + AW'(1) : rd_q;
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < RES_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      if (do_push) mem_q[wr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/fpu_operand_sequencer.sv
// Floating-point core front end: assembles A/B operand pairs, runs the core strobe/ack handshakes,
// queues results, and owns the core reset (synchronised release plus watchdog recovery pulse).
module fpu_operand_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int OPSEL_W   = 2,
  parameter int RES_DEPTH = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  fpu_operand_sequencer_if.slave     bus,
  output logic                       fpu_rst,
  output logic [$clog2(RES_DEPTH):0] out_level,
  output logic                       busy,
  output logic                       err_timeout,
  input  logic                       err_clr,
  output logic [1:0]                 dbg_state
);

  localparam int              CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   WD_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic            WD_EN   = (TIMEOUT > 0);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [OPSEL_W-1:0] op_q, op_d;
  logic               a_stb_q, a_stb_d;
  logic               b_stb_q, b_stb_d;
  logic [CW-1:0]      wd_cnt_q, wd_cnt_d;
  logic               err_q, err_d;
  logic               wd_rst_q;
  logic [1:0]         sync_q;
  logic               core_rdy_q;

  logic in_ready_w, in_fire, z_ack_w, capture, in_flight, wd_fire;
  logic fifo_full, fifo_empty;

  // Core reset asserts with rst_n and releases on the second clk edge after rst_n rises;
  // inputs open one cycle after any core reset ends.
  assign fpu_rst    = !sync_q[1] || wd_rst_q;
  assign in_ready_w = ((state_q == LOAD_A) || (state_q == LOAD_B)) && core_rdy_q && !fpu_rst;
  assign in_fire    = bus.in_valid && in_ready_w;
  assign z_ack_w    = (state_q == WAIT_Z) && !fifo_full;
  assign capture    = z_ack_w && bus.fpu_z_stb;
  assign in_flight  = (state_q == ISSUE) || (state_q == WAIT_Z);
  assign wd_fire    = WD_EN && in_flight && (wd_cnt_q == WD_LAST) && !capture;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    a_stb_d  = a_stb_q;
    b_stb_d  = b_stb_q;
    wd_cnt_d = in_flight ? wd_cnt_q + CW'(1) : wd_cnt_q;
    case (state_q)
      LOAD_A: if (in_fire) begin
        a_d     = bus.in_data;
        op_d    = bus.in_op_sel;
        state_d = LOAD_B;
      end
      LOAD_B: if (in_fire) begin
        b_d      = bus.in_data;
        a_stb_d  = 1'b1;
        b_stb_d  = 1'b1;
        wd_cnt_d = '0;
        state_d  = ISSUE;
      end
      ISSUE: begin
        if (bus.fpu_a_ack) a_stb_d = 1'b0;
        if (bus.fpu_b_ack) b_stb_d = 1'b0;
        if (!a_stb_d && !b_stb_d) state_d = WAIT_Z;
      end
      WAIT_Z: if (capture) state_d = LOAD_A;
      default: state_d = LOAD_A;
    endcase
    // A hung core abandons the operation; the result FIFO is left untouched.
    if (wd_fire) begin
      state_d = LOAD_A;
      a_stb_d = 1'b0;
      b_stb_d = 1'b0;
    end
    err_d = wd_fire ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      a_stb_q    <= 1'b0;
      b_stb_q    <= 1'b0;
      wd_cnt_q   <= '0;
      err_q      <= 1'b0;
      wd_rst_q   <= 1'b0;
      sync_q     <= 2'b00;
      core_rdy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      a_stb_q    <= a_stb_d;
      b_stb_q    <= b_stb_d;
      wd_cnt_q   <= wd_cnt_d;
      err_q      <= err_d;
      wd_rst_q   <= wd_fire;
      sync_q     <= {sync_q[0], 1'b1};
      core_rdy_q <= !fpu_rst;
    end
  end

  seq_result_fifo #(
    .WIDTH     (WIDTH),
    .RES_DEPTH (RES_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (capture),
    .push_data_i (bus.fpu_z),
    .pop_i       (bus.out_ready),
    .head_o      (bus.out_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (out_level)
  );

  assign bus.in_ready   = in_ready_w;
  assign bus.fpu_a      = a_q;
  assign bus.fpu_b      = b_q;
  assign bus.fpu_op_sel = op_q;
  assign bus.fpu_a_stb  = a_stb_q;
  assign bus.fpu_b_stb  = b_stb_q;
  assign bus.fpu_z_ack  = z_ack_w;
  assign bus.out_valid  = !fifo_empty;
  assign busy           = (state_q != LOAD_A);
  assign err_timeout    = err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_fpu_operand_sequencer.sv
// Directed bench for fpu_operand_sequencer: reset release, operand flow, ack ordering,
// FIFO full/ordering, watchdog recovery and mid-operation reset.
module tb_fpu_operand_sequencer;
  import fpu_seq_pkg::*;

  localparam int W = 32;

  logic       clk;
  logic       rst_n;
  logic [2:0] out_level;
  logic       fpu_rst, busy, err_timeout, err_clr;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  fpu_operand_sequencer_if #(.WIDTH(W), .OPSEL_W(2)) bus ();

  fpu_operand_sequencer #(
    .WIDTH(W), .OPSEL_W(2), .RES_DEPTH(4), .TIMEOUT(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .fpu_rst     (fpu_rst),
    .out_level   (out_level),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_clr     (err_clr),
    .dbg_state   (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic send_word(input logic [W-1:0] d, input logic [1:0] op);
    int waited;
    waited = 0;
    bus.in_data   = d;
    bus.in_op_sel = op;
    bus.in_valid  = 1'b1;
    while (!bus.in_ready && waited < 40) begin
      tick();
      waited++;
    end
    chk("in_ready_wait", 64'(waited < 40), 64'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic ack_both();
    bus.fpu_a_ack = 1'b1;
    bus.fpu_b_ack = 1'b1;
    tick();
    bus.fpu_a_ack = 1'b0;
    bus.fpu_b_ack = 1'b0;
  endtask

  task automatic return_z(input logic [W-1:0] z, input logic pop);
    int waited;
    waited = 0;
    bus.fpu_z     = z;
    bus.fpu_z_stb = 1'b1;
    bus.out_ready = pop;
    while (!bus.fpu_z_ack && waited < 40) begin
      tick();
      waited++;
    end
    chk("z_ack_wait", 64'(waited < 40), 64'd1);
    tick();
    bus.fpu_z_stb = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [1:0] op, input logic [W-1:0] b,
                       input logic [W-1:0] z, input logic pop);
    send_word(a, op);
    send_word(b, 2'd0);
    ack_both();
    return_z(z, pop);
  endtask

  initial begin
    rst_n = 1'b0;
    err_clr = 1'b0;
    bus.in_data = '0; bus.in_op_sel = '0; bus.in_valid = 1'b0;
    bus.fpu_a_ack = 1'b0; bus.fpu_b_ack = 1'b0;
    bus.fpu_z = '0; bus.fpu_z_stb = 1'b0; bus.out_ready = 1'b0;

    // reset values
    tick(); tick();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_fpu_rst", fpu_rst, 1);
    chk("rst_fpu_a", bus.fpu_a, 0);
    chk("rst_fpu_b", bus.fpu_b, 0);
    chk("rst_op_sel", bus.fpu_op_sel, 0);
    chk("rst_stbs", {bus.fpu_a_stb, bus.fpu_b_stb, bus.fpu_z_ack}, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_level", out_level, 0);
    chk("rst_busy_err", {busy, err_timeout}, 0);
    chk("rst_state", dbg_state, LOAD_A);

    // reset release: fpu_rst falls at 2nd edge, in_ready one cycle later
    rst_n = 1'b1;
    tick();
    chk("rel_e1_fpu_rst", fpu_rst, 1);
    tick();
    chk("rel_e2_fpu_rst", fpu_rst, 0);
    chk("rel_e2_in_ready", bus.in_ready, 0);
    tick();
    chk("rel_e3_in_ready", bus.in_ready, 1);

    // basic op; opcode offered with B must be ignored
    send_word(32'h3F80_0000, OP_ADD);
    chk("basic_fpu_a", bus.fpu_a, 32'h3F80_0000);
    chk("basic_state_b", dbg_state, LOAD_B);
    chk("basic_busy", busy, 1);
    send_word(32'h4000_0000, OP_DIV);
    chk("basic_fpu_b", bus.fpu_b, 32'h4000_0000);
    chk("basic_op_sel", bus.fpu_op_sel, OP_ADD);
    chk("basic_stbs_on", {bus.fpu_a_stb, bus.fpu_b_stb}, 2'b11);
    chk("basic_state_issue", dbg_state, ISSUE);
    ack_both();
    chk("basic_stbs_off", {bus.fpu_a_stb, bus.fpu_b_stb}, 2'b00);
    chk("basic_state_waitz", dbg_state, WAIT_Z);
    chk("basic_z_ack", bus.fpu_z_ack, 1);
    return_z(32'h4040_0000, 1'b0);
    chk("basic_out_valid", bus.out_valid, 1);
    chk("basic_out_data", bus.out_data, 32'h4040_0000);
    chk("basic_out_level", out_level, 1);
    chk("basic_in_ready", bus.in_ready, 1);
    chk("basic_state_a", dbg_state, LOAD_A);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("basic_pop_level", out_level, 0);
    chk("basic_pop_valid", bus.out_valid, 0);

    // staggered acks: B first, stray B ack while low, A three cycles later
    send_word(32'h1111_1111, OP_SUB);
    send_word(32'h2222_2222, OP_MUL);
    bus.fpu_b_ack = 1'b1;
    tick();
    bus.fpu_b_ack = 1'b0;
    chk("stag_b_drop", {bus.fpu_a_stb, bus.fpu_b_stb}, 2'b10);
    chk("stag_state1", dbg_state, ISSUE);
    bus.fpu_b_ack = 1'b1;
    tick();
    bus.fpu_b_ack = 1'b0;
    chk("stag_stray_ack", {bus.fpu_a_stb, bus.fpu_b_stb}, 2'b10);
    chk("stag_state2", dbg_state, ISSUE);
    tick();
    chk("stag_state3", dbg_state, ISSUE);
    bus.fpu_a_ack = 1'b1;
    tick();
    bus.fpu_a_ack = 1'b0;
    chk("stag_a_drop", {bus.fpu_a_stb, bus.fpu_b_stb}, 2'b00);
    chk("stag_state_waitz", dbg_state, WAIT_Z);
    chk("stag_op_sel", bus.fpu_op_sel, OP_SUB);
    return_z(32'h3333_3333, 1'b0);
    chk("stag_out_data", bus.out_data, 32'h3333_3333);
    bus.out_ready = 1'b1;
    tick();
    chk("stag_pop_level", out_level, 0);
    tick();
    bus.out_ready = 1'b0;
    chk("pop_empty_level", out_level, 0);

    // push and pop in the same cycle keep the level
    do_op(32'h1, OP_MUL, 32'h2, 32'hAAAA_0001, 1'b0);
    do_op(32'h3, OP_MUL, 32'h4, 32'hAAAA_0002, 1'b1);
    chk("pushpop_level", out_level, 1);
    chk("pushpop_head", bus.out_data, 32'hAAAA_0002);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // fill FIFO to 4 with no consumer
    for (int i = 1; i <= 4; i++) begin
      do_op(32'(i), OP_ADD, 32'(i + 10), 32'hC000_0000 + 32'(i), 1'b0);
      exp_q.push_back(32'hC000_0000 + 32'(i));
    end
    chk("full_level", out_level, 4);
    send_word(32'h5, OP_ADD);
    send_word(32'h15, OP_ADD);
    ack_both();
    bus.fpu_z = 32'hC000_0005;
    bus.fpu_z_stb = 1'b1;
    chk("full_z_ack0", bus.fpu_z_ack, 0);
    chk("full_state", dbg_state, WAIT_Z);
    tick();
    chk("full_hold_level", out_level, 4);
    bus.out_ready = 1'b1;
    chk("full_pop_cycle_ack", bus.fpu_z_ack, 0);
    tick();
    bus.out_ready = 1'b0;
    void'(exp_q.pop_front());
    chk("full_after_pop_level", out_level, 3);
    chk("full_after_pop_ack", bus.fpu_z_ack, 1);
    tick();
    bus.fpu_z_stb = 1'b0;
    exp_q.push_back(32'hC000_0005);
    chk("full_refill_level", out_level, 4);
    chk("full_refill_state", dbg_state, LOAD_A);
    // scoreboard drain
    while (exp_q.size() > 0) begin
      chk("drain_data", bus.out_data, exp_q.pop_front());
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    chk("drain_level", out_level, 0);

    // watchdog: core never answers
    send_word(32'hDEAD_0001, OP_DIV);
    send_word(32'hDEAD_0002, OP_DIV);
    for (int i = 0; i < 15; i++) tick();
    chk("wd_pre_err", err_timeout, 0);
    chk("wd_pre_state", dbg_state, ISSUE);
    chk("wd_pre_fpu_rst", fpu_rst, 0);
    tick();
    chk("wd_err", err_timeout, 1);
    chk("wd_fpu_rst", fpu_rst, 1);
    chk("wd_state", dbg_state, LOAD_A);
    chk("wd_stbs", {bus.fpu_a_stb, bus.fpu_b_stb}, 2'b00);
    chk("wd_in_ready", bus.in_ready, 0);
    chk("wd_no_push", out_level, 0);
    tick();
    chk("wd_pulse_end", fpu_rst, 0);
    chk("wd_err_sticky", err_timeout, 1);
    tick();
    chk("wd_in_ready_back", bus.in_ready, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("wd_err_clr", err_timeout, 0);

    // watchdog with err_clr held: set wins, then clear
    err_clr = 1'b1;
    send_word(32'hBEEF_0001, OP_ADD);
    send_word(32'hBEEF_0002, OP_ADD);
    for (int i = 0; i < 15; i++) tick();
    chk("wd2_pre_err", err_timeout, 0);
    tick();
    chk("wd2_set_wins", err_timeout, 1);
    tick();
    chk("wd2_cleared", err_timeout, 0);
    err_clr = 1'b0;

    // mid-operation reset with two results queued
    do_op(32'h7, OP_SUB, 32'h8, 32'h5555_0001, 1'b0);
    do_op(32'h9, OP_SUB, 32'hA, 32'h5555_0002, 1'b0);
    send_word(32'hB, OP_MUL);
    send_word(32'hC, OP_MUL);
    ack_both();
    chk("mid_state", dbg_state, WAIT_Z);
    chk("mid_level", out_level, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", bus.out_valid, 0);
    chk("mid_out_level", out_level, 0);
    chk("mid_stbs", {bus.fpu_a_stb, bus.fpu_b_stb, bus.fpu_z_ack}, 0);
    chk("mid_fpu_rst", fpu_rst, 1);
    chk("mid_busy", busy, 0);
    chk("mid_in_ready", bus.in_ready, 0);
    tick();

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
